// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing an 8:1 single-bit mux, with bounded tenure.
// Optional MUX8_ARB_PRIO0_EN: requester 0 wins every IDLE arbitration.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] in,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       q,
  output logic       q_valid,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] LIM =
    CNT_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);

  state_t           state;
  state_t           state_d;
  logic [2:0]       last;
  logic [2:0]       off;
  logic [2:0]       idx;
  logic [2:0]       win;
  logic             found;
  logic [7:0]       rr_req;
  logic [CNT_W-1:0] hold_cnt;
  logic             rel;

  // Search starts just after the last winner so it ends up lowest priority
  always_comb begin
    rr_req = req;
`ifdef MUX8_ARB_PRIO0_EN
    rr_req[0] = 1'b0;
`endif
    off   = last + 3'd1;
    win   = off;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = off + 3'(i);
      if (!found && rr_req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
`ifdef MUX8_ARB_PRIO0_EN
    if (req[0]) win = 3'd0;
`endif
  end

  assign rel = !req[sel] ||
               ((MAX_HOLD != 0) && (hold_cnt == LIM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (1'b1)
      state == IDLE:  if (|req) state_d = GRANT;
      state == GRANT: if (rel)  state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == GRANT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      sel      <= '0;
      q        <= 1'b0;
      q_valid  <= 1'b0;
      hold_cnt <= '0;
      last     <= 3'd7;
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          if (|req) begin
            gnt      <= 8'd1 << win;
            sel      <= win;
            last     <= win;
            hold_cnt <= '0;
          end
        end
        state == GRANT: begin
          if (rel) begin
            gnt      <= '0;
            q_valid  <= 1'b0;
            hold_cnt <= '0;
          end else begin
            q       <= in[sel];
            q_valid <= 1'b1;
            if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          gnt     <= '0;
          q_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
